branch_predictor_nway: RTL
==========================

# branch_predictor_nway

Parametrised next-generation branch predictor for the fetch stage: a banked BTB with one bank per instruction slot of a SLOTS-wide fetch packet, 2-bit saturating direction counters and a speculative return-address stack (RAS) with misprediction recovery. It predicts the next fetch PC one cycle after an IF request. It is trained by resolved branches from EX.

## Interface
- ADDR_WIDTH, 32, address width
- SLOTS, 2, instructions per fetch packet (power of 2, ≥2); SW = log2(SLOTS)
- INDEX_WIDTH, 6, BTB index bits (2^INDEX_WIDTH entries per bank)
- TAG_WIDTH, 10, BTB tag bits
- RAS_DEPTH, 8, RAS entries (power of 2)

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- ifVld  in  1  prediction request
- ifPC  in  ADDR_WIDTH  fetch PC (word aligned, may point mid-packet)
- exVld  in  1  EX update valid
- exPC  in  ADDR_WIDTH  PC of resolved instruction
- exPCTar  in  ADDR_WIDTH  resolved target
- exType  in  2  00 none, 01 conditional, 10 jump, 11 return
- exLink  in  1  jump writes link register (call)
- exBranch  in  1  instruction actually branched
- exWrong  in  1  EX detected misprediction
- pdVld  out  1  prediction valid
- pdPC  out  ADDR_WIDTH  predicted next fetch PC
- pdBranch  out  1  taken branch predicted
- pdSlot  out  SW (min 1)  slot of the predicting instruction
- pdKnown  out  1  at least one BTB hit in the considered slots

## Operation
- Address split: slot = PC[SW+1:2], index = PC[SW+INDEX_WIDTH+1:SW+2], tag = next TAG_WIDTH bits. packet base = PC with bits [SW+1:0] cleared.
- Bank entry: valid, tag, target[ADDR_WIDTH-1:2], type, link, ctr[1:0].
- Lookup: for each slot s ≥ slot(ifPC), hit_s = valid & tag match. taken_s = hit_s & (type==10 | type==11 | (type==01 & ctr[1])). The lowest taken s wins.
- Target for the winning slot:
  - type 11 with RAS count>0 → RAS top.
  - Otherwise → BTB target.
- No taken slot → pdPC = packet base + 4·SLOTS, pdBranch=0, pdSlot=0.
- Speculative RAS (on a request that produces pdVld=1):
  - Winning slot type 10 with link → push (packet base + 4·s + 4).
  - Winning slot type 11 with count>0 → pop.
  - Push on full: pointer wraps and overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop on empty: no state change.
- Training (exVld=1):
  - exType≠00, miss or tag mismatch → allocate: valid=1, tag, target, type, link=exLink, ctr = exBranch ? 10 : 01.
  - exType≠00, hit → refresh target/type/link; ctr saturating +1 if exBranch, else −1 (bounded 00..11).
  - exType=00 and hit → clear valid (alias removal).
- Committed RAS: a separate pointer/count updated by EX.
  - exType 10 & exLink & exBranch → push.
  - exType 11 & exBranch & count>0 → pop.
  - The committed copy does not write the array.
- Recovery: exWrong=1 with exVld=1 → speculative pointer/count ← committed pointer/count after this cycle's committed update. Array contents are not restored.

## Timing
- Reset (async): all valid bits and counters 0, both RAS pointers/counts 0. pdVld, pdPC, pdBranch, pdSlot, pdKnown all 0.
- Latency 1: request at edge t → outputs registered at t+1. pdVld(t+1) = ifVld(t) & ~(exVld & exWrong)(t).
- Outputs hold their last values when pdVld=0. pdVld is a one-cycle pulse per request; there is no stall handshake.
- A training write at edge t is visible to lookups sampled from edge t+1 onward. A same-cycle lookup reads the old contents; there is no bypass.
- Recovery and a speculative push/pop in the same cycle: recovery wins and the speculative op is discarded.
- Reset asserted mid-operation clears state immediately; the first prediction is possible at the first edge after rstn rises.

## Test plan
- Reset, then ifVld with ifPC=0x1000, SLOTS=2 → at the next cycle pdVld=1, pdPC=0x1008, pdBranch=0, pdKnown=0.
- Train a conditional at 0x1004 to 0x2000 with exBranch=1 once (ctr=10), then request ifPC=0x1000 → pdPC=0x2000, pdSlot=1, pdKnown=1. Train exBranch=0 twice (ctr=00), then request again → pdPC=0x1008, pdKnown=1.
- Request ifPC=0x1004 with taken entries in both slots 0 and 1 → slot 0 ignored, pdSlot=1. With slot 0 requested → slot 0 wins.
- Call at 0x3000 (type 10, link) to 0x4000, return at 0x4010 (type 11): predict the call, then the return → return pdPC=0x3004. Perform 9 calls with RAS_DEPTH=8 → oldest entry overwritten; the 9th pop falls back to the BTB target.
- Two speculative calls pushed, then exVld with exWrong=1 and committed count 0 in the same cycle as an ifVld → pdVld=0 next cycle. A following return prediction uses the BTB target because the RAS is empty.
- Alias: train 0x1000, then exVld with exType=00 at 0x1000 → the next lookup has pdKnown=0.

Source files
------------

// File: rtl/branch_predictor_nway.sv
// branch_predictor_nway: next-fetch-PC predictor for a SLOTS-wide fetch packet.
// It has one BTB bank per packet slot, 2-bit direction counters, and a
// speculative return-address stack. A committed copy of the RAS pointer and
// count is kept so a misprediction can restore the speculative copy.
//
// Ports
//   clk, rstn                 clock, async active-low reset
//   ifVld, ifPC               prediction request (answered one cycle later)
//   exVld, exPC, exPCTar,     resolved-branch training from EX
//   exType, exLink,           exType: 00 none, 01 cond, 10 jump, 11 return
//   exBranch, exWrong
//   pdVld, pdPC, pdBranch,    registered prediction; holds while pdVld=0
//   pdSlot, pdKnown

// One BTB bank. Port a serves fetch lookup, port b serves the EX
// read-modify-write, and w is the training write.
module bp_bank #(
  parameter int IW = 6,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [IW-1:0] ra,
  input  logic [IW-1:0] rb,
  output logic [EW-1:0] qa,
  output logic [EW-1:0] qb,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [EW-1:0] wd
);
  logic [EW-1:0] mem [2**IW];

  assign qa = mem[ra];
  assign qb = mem[rb];

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) for (int i = 0; i < 2**IW; i++) mem[i] <= '0;
    else if (we) mem[wa] <= wd;
endmodule

module branch_predictor_nway #(
  parameter int ADDR_WIDTH  = 32,
  parameter int SLOTS       = 2,
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 10,
  parameter int RAS_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ifVld,
  input  logic [ADDR_WIDTH-1:0] ifPC,
  input  logic                  exVld,
  input  logic [ADDR_WIDTH-1:0] exPC,
  input  logic [ADDR_WIDTH-1:0] exPCTar,
  input  logic [1:0]            exType,
  input  logic                  exLink,
  input  logic                  exBranch,
  input  logic                  exWrong,
  output logic                  pdVld,
  output logic [ADDR_WIDTH-1:0] pdPC,
  output logic                  pdBranch,
  output logic [$clog2(SLOTS)-1:0] pdSlot,
  output logic                  pdKnown
);
  localparam int SW = $clog2(SLOTS);
  localparam int RW = $clog2(RAS_DEPTH);
  localparam int TL = SW + INDEX_WIDTH + 2;  // lsb of tag field

  typedef struct packed {
    logic                  vld;
    logic [TAG_WIDTH-1:0]  tag;
    logic [ADDR_WIDTH-3:0] tar;
    logic [1:0]            typ;
    logic                  lnk;
    logic [1:0]            ctr;
  } ent_t;
  localparam int EW = $bits(ent_t);

  // Address split
  logic [SW-1:0]          if_slot, ex_slot;
  logic [INDEX_WIDTH-1:0] if_idx, ex_idx;
  logic [TAG_WIDTH-1:0]   if_tag, ex_tag;
  assign if_slot = ifPC[SW+1:2];
  assign if_idx  = ifPC[TL-1:SW+2];
  assign if_tag  = ifPC[TL+TAG_WIDTH-1:TL];
  assign ex_slot = exPC[SW+1:2];
  assign ex_idx  = exPC[TL-1:SW+2];
  assign ex_tag  = exPC[TL+TAG_WIDTH-1:TL];

  logic unused_bits;
  assign unused_bits = ^{ifPC[1:0], exPC[1:0], exPC[ADDR_WIDTH-1:TL+TAG_WIDTH], exPCTar[1:0]};

  // Banks
  logic [SLOTS-1:0][EW-1:0] rd_if, rd_ex;
  logic [SLOTS-1:0]         bank_we;
  ent_t                     wr_ent;

  bp_bank #(.IW(INDEX_WIDTH), .EW(EW)) u_bank [SLOTS-1:0] (
    .clk(clk), .rstn(rstn), .ra(if_idx), .rb(ex_idx), .qa(rd_if), .qb(rd_ex),
    .we(bank_we), .wa(ex_idx), .wd(wr_ent)
  );

  // Lookup: only slots at or after the fetch entry point are considered
  ent_t [SLOTS-1:0] e_if;
  logic [SLOTS-1:0] hit, taken;
  assign e_if = rd_if;

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    assign hit[s]   = e_if[s].vld && (e_if[s].tag == if_tag) && (if_slot <= SW'(s));
    assign taken[s] = hit[s] && (e_if[s].typ[1] || (e_if[s].typ == 2'b01 && e_if[s].ctr[1]));
  end

  logic [SW-1:0] win;
  logic          any;
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int s = SLOTS-1; s >= 0; s--)
      if (taken[s]) begin
        win = SW'(s);
        any = 1'b1;
      end
  end

  // RAS state
  logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];
  logic [RW-1:0]         sptr, cptr, cptr_nx;
  logic [RW:0]           scnt, ccnt, ccnt_nx;
  localparam logic [RW:0] FULL = (RW+1)'(RAS_DEPTH);

  ent_t                  win_e;
  logic                  use_ras, recover, req, push, pop;
  logic [ADDR_WIDTH-1:0] base, pred_pc, link_addr;

  assign win_e     = e_if[win];
  assign base      = {ifPC[ADDR_WIDTH-1:SW+2], {(SW+2){1'b0}}};
  assign link_addr = {ifPC[ADDR_WIDTH-1:SW+2], win, 2'b00} + ADDR_WIDTH'(4);
  assign use_ras   = any && (win_e.typ == 2'b11) && (scnt != '0);
  assign pred_pc   = !any    ? base + ADDR_WIDTH'(4*SLOTS) :
                     use_ras ? ras[sptr - 1'b1] : {win_e.tar, 2'b00};
  assign recover   = exVld && exWrong;
  // A recovering cycle suppresses the request, so recovery always beats
  // a speculative push/pop.
  assign req       = ifVld && !recover;
  assign push      = req && any && (win_e.typ == 2'b10) && win_e.lnk;
  assign pop       = req && use_ras;

  // Committed RAS follows resolved calls/returns only
  always_comb begin
    cptr_nx = cptr;
    ccnt_nx = ccnt;
    if (exVld && exBranch && exType == 2'b10 && exLink) begin
      cptr_nx = cptr + 1'b1;
      if (ccnt != FULL) ccnt_nx = ccnt + 1'b1;
    end else if (exVld && exBranch && exType == 2'b11 && ccnt != '0) begin
      cptr_nx = cptr - 1'b1;
      ccnt_nx = ccnt - 1'b1;
    end
  end

  // Training: allocate on miss, refresh/count on hit, none-type hit drops alias
  ent_t ex_e;
  logic ex_hit, we_any;
  assign ex_e   = rd_ex[ex_slot];
  assign ex_hit = ex_e.vld && (ex_e.tag == ex_tag);

  always_comb begin
    wr_ent = ex_e;
    we_any = 1'b0;
    if (exVld && exType != 2'b00) begin
      we_any     = 1'b1;
      wr_ent.vld = 1'b1;
      wr_ent.tag = ex_tag;
      wr_ent.tar = exPCTar[ADDR_WIDTH-1:2];
      wr_ent.typ = exType;
      wr_ent.lnk = exLink;
      if (!ex_hit)       wr_ent.ctr = exBranch ? 2'b10 : 2'b01;
      else if (exBranch) wr_ent.ctr = (ex_e.ctr == 2'b11) ? 2'b11 : ex_e.ctr + 2'b01;
      else               wr_ent.ctr = (ex_e.ctr == 2'b00) ? 2'b00 : ex_e.ctr - 2'b01;
    end else if (exVld && ex_hit) begin
      we_any     = 1'b1;
      wr_ent.vld = 1'b0;
    end
  end
  assign bank_we = we_any ? (SLOTS'(1) << ex_slot) : '0;

  // RAS array has no reset: entries are only read below the count
  always_ff @(posedge clk)
    if (push) ras[sptr] <= link_addr;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sptr <= '0; scnt <= '0; cptr <= '0; ccnt <= '0;
    end else begin
      cptr <= cptr_nx;
      ccnt <= ccnt_nx;
      if (recover) begin
        sptr <= cptr_nx;
        scnt <= ccnt_nx;
      end else if (push) begin
        sptr <= sptr + 1'b1;
        if (scnt != FULL) scnt <= scnt + 1'b1;
      end else if (pop) begin
        sptr <= sptr - 1'b1;
        scnt <= scnt - 1'b1;
      end
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pdVld <= 1'b0; pdPC <= '0; pdBranch <= 1'b0; pdSlot <= '0; pdKnown <= 1'b0;
    end else begin
      pdVld <= req;
      if (req) begin
        pdPC     <= pred_pc;
        pdBranch <= any;
        pdSlot   <= win;
        pdKnown  <= |hit;
      end
    end
endmodule
